// File: rtl/mem_port_requester_pkg.sv
// mem_port_pkg: shared width helpers and RAM timing constants for the memory port requester
package mem_port_pkg;
  localparam int RD_LATENCY = 1;
  function automatic int strb_w(input int dw);
    return (dw + 7) / 8;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_port_requester_if.sv
// mem_port_requester_if: client request/response streams between a client and the memory port requester
interface mem_port_requester_if import mem_port_pkg::*; #(
  parameter int DW = 128,
  parameter int AW = 14
);
  localparam int SW = strb_w(DW);
  logic req_valid;
  logic req_ready;
  logic [SW-1:0] req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DW-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_port_requester_fifo.sv
// mem_rsp_fifo: synchronous response FIFO holding captured RAM read data until the client takes it
module mem_rsp_fifo import mem_port_pkg::*; #(
  parameter int DATAWIDTH = 128,
  parameter int DEPTH = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic [ptr_w(DEPTH):0] occ,
  output logic empty
);
  localparam int PW = ptr_w(DEPTH);
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_pop;
  assign empty = occ == '0;
  assign do_pop = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(do_pop);
      occ <= occ + (PW+1)'(push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/mem_port_requester.sv
// mem_port_requester: credit-based initiator for one RAM port with buffered in-order read responses
module mem_port_requester import mem_port_pkg::*; #(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14,
  parameter int RSP_DEPTH = 4
)(
  input  logic clk,
  input  logic reset,
  mem_port_requester_if.slave cl,
  output logic mem_en,
  output logic [strb_w(MEM_DATAWIDTH)-1:0] mem_we,
  output logic [MEM_ADDRWIDTH-1:0] mem_addr,
  output logic [MEM_DATAWIDTH-1:0] mem_din,
  input  logic [MEM_DATAWIDTH-1:0] mem_dout,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  localparam int PW = ptr_w(RSP_DEPTH);
  logic infl, empty, fire, rd_fire;
  logic [PW:0] occ;
  // a slot is reserved for every read still in the RAM pipeline
  assign cl.req_ready = !reset && (32'(occ) + 32'(infl) < RSP_DEPTH);
  assign fire = cl.req_valid & cl.req_ready;
  assign rd_fire = fire & ~|cl.req_we;
  assign mem_en = fire;
  assign mem_we = fire ? cl.req_we : '0;
  assign mem_addr = cl.req_addr;
  assign mem_din = cl.req_wdata;
  assign cl.rsp_valid = !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      infl <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      infl <= rd_fire;
      rd_cnt <= rd_cnt + 32'(rd_fire);
      wr_cnt <= wr_cnt + 32'(fire & !rd_fire);
    end
  mem_rsp_fifo #(.DATAWIDTH(MEM_DATAWIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(infl),
    .pop(cl.rsp_valid & cl.rsp_ready),
    .din(mem_dout),
    .dout(cl.rsp_rdata),
    .occ(occ),
    .empty(empty)
  );
endmodule
